// File: rtl/tp_mux_ctrl.sv
// rtl/tp_mux_ctrl.sv - debug test-point group mux with change blanking, auto-scan and trigger freeze
module tp_mux_ctrl #(
  parameter int NGRP    = 8,
  parameter int GW      = 16,
  parameter int DWELL_W = 16,
  parameter int BLANK   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NGRP*GW-1:0]      GRP_DATA,
  input  logic                    CFG_WE,
  input  logic [7:0]              CFG_DATA,
  input  logic [DWELL_W-1:0]      DWELL,
  input  logic                    TRIG,
  output logic [GW-1:0]           TP_OUT,
  output logic [$clog2(NGRP)-1:0] TP_SEL,
  output logic                    TP_VALID,
  output logic                    FROZEN,
  output logic                    SYNC_PULSE
);

  localparam int SW = $clog2(NGRP);
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);

  typedef enum logic [1:0] {S_BLANK, S_RUN, S_FRZ} state_t;

  state_t             state_q, state_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic               auto_q, auto_d;
  logic               arm_q, arm_d;
  logic [GW-1:0]      out_q, out_d;
  logic               valid_q, valid_d;
  logic               frozen_q, frozen_d;
  logic               sync_q, sync_d;

  logic [SW-1:0]      cfg_sel;
  logic [GW-1:0]      grp_word;
  logic               dwell_hit;
  logic               unused_cfg;

  assign cfg_sel    = CFG_DATA[SW-1:0];
  assign grp_word   = GRP_DATA[int'(sel_q)*GW +: GW];
  assign dwell_hit  = auto_q && (DWELL != '0) && (dcnt_q == DWELL - DWELL_W'(1));
  assign unused_cfg = ^CFG_DATA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_BLANK;
      bcnt_q   <= '0;
      dcnt_q   <= '0;
      sel_q    <= '0;
      auto_q   <= 1'b0;
      arm_q    <= 1'b0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      frozen_q <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      dcnt_q   <= dcnt_d;
      sel_q    <= sel_d;
      auto_q   <= auto_d;
      arm_q    <= arm_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      frozen_q <= frozen_d;
      sync_q   <= sync_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    dcnt_d   = dcnt_q;
    sel_d    = sel_q;
    auto_d   = auto_q;
    arm_d    = arm_q;
    out_d    = out_q;
    valid_d  = valid_q;
    frozen_d = frozen_q;
    sync_d   = 1'b0;

    unique case (state_q)
      S_BLANK: begin
        if (CFG_WE) begin
          sel_d  = cfg_sel;
          auto_d = CFG_DATA[4];
          arm_d  = CFG_DATA[5];
          bcnt_d = '0;
        end else if (bcnt_q == BLANK_LAST) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          sync_d  = 1'b1;
          out_d   = grp_word;
          dcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end

      S_RUN: begin
        // Priority: group change, config refresh, trigger, dwell expiry.
        if (CFG_WE && (cfg_sel != sel_q)) begin
          sel_d   = cfg_sel;
          auto_d  = CFG_DATA[4];
          arm_d   = CFG_DATA[5];
          state_d = S_BLANK;
          bcnt_d  = '0;
          out_d   = '0;
          valid_d = 1'b0;
        end else if (CFG_WE) begin
          auto_d = CFG_DATA[4];
          arm_d  = CFG_DATA[5];
          out_d  = grp_word;
          if (!CFG_DATA[4]) dcnt_d = '0;
        end else if (arm_q && TRIG) begin
          state_d  = S_FRZ;
          frozen_d = 1'b1;
          out_d    = grp_word;
        end else if (dwell_hit) begin
          sel_d   = sel_q + 1'b1;
          state_d = S_BLANK;
          bcnt_d  = '0;
          out_d   = '0;
          valid_d = 1'b0;
        end else begin
          out_d  = grp_word;
          dcnt_d = auto_q ? dcnt_q + 1'b1 : '0;
        end
      end

      S_FRZ: begin
        if (CFG_WE) begin
          sel_d    = cfg_sel;
          auto_d   = CFG_DATA[4];
          arm_d    = CFG_DATA[5];
          state_d  = S_BLANK;
          bcnt_d   = '0;
          out_d    = '0;
          valid_d  = 1'b0;
          frozen_d = 1'b0;
        end
      end

      default: state_d = S_BLANK;
    endcase
  end

  assign TP_OUT     = out_q;
  assign TP_SEL     = sel_q;
  assign TP_VALID   = valid_q;
  assign FROZEN     = frozen_q;
  assign SYNC_PULSE = sync_q;

endmodule
